// File: rtl/alu_div8.sv
// Sequential unsigned divider: restoring shift-and-subtract, one quotient bit per cycle,
// with a start/busy/done handshake so the control unit can stall on it.
module alu_div8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  count;
  logic [WIDTH-1:0] dq;        // dividend shifts out the top while quotient bits enter the bottom
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   prem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign shifted = {prem[WIDTH-1:0], dq[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (data2 != '0) ? CALC : FINISH;
      CALC:    if (count == '0) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == FINISH);
  end

  // Datapath and result registers; results only change on the edge that enters FINISH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      dq          <= '0;
      divisor     <= '0;
      prem        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (data2 != '0) begin
              dq      <= data1;
              divisor <= data2;
              prem    <= '0;
              count   <= CW'(WIDTH);
            end else begin
              quotient    <= '1;
              remainder   <= data1;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          if (count != '0) begin
            if (!trial[WIDTH]) begin
              prem <= trial;
              dq   <= {dq[WIDTH-2:0], 1'b1};
            end else begin
              prem <= shifted;
              dq   <= {dq[WIDTH-2:0], 1'b0};
            end
            count <= count - CW'(1);
          end else begin
            quotient    <= dq;
            remainder   <= prem[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div8.sv
// Directed self-checking bench for alu_div8: reset, nominal, boundary, divide-by-zero,
// held start with changing operands, and reset during a calculation.
module tb_alu_div8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] data1, data2;
  logic [7:0] quotient, remainder;
  logic       busy, done, div_by_zero;

  int checks   = 0;
  int failures = 0;
  int done_at;
  int busy_cycles;

  alu_div8 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data1      (data1),
    .data2      (data2),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Watch from the current negedge (n=1) until done or budget runs out; ends on the done cycle.
  task automatic wait_done();
    done_at     = 0;
    busy_cycles = 0;
    for (int n = 1; n <= 30; n++) begin
      if (n > 1) @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_at = n;
        break;
      end
    end
  endtask

  // Called on a negedge; issues a one-cycle start and waits for done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    data1 = a;
    data2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    data1 = 8'd0;
    data2 = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: q=%0d r=%0d busy=%b done=%b dz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle: cycle %0d busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    run_op(8'd200, 8'd7);
    checks++;
    if (done_at !== 10 || busy_cycles !== 9) begin
      failures++;
      $display("FAIL basic_timing: done_at=%0d busy_cycles=%0d, want 10 9", done_at, busy_cycles);
    end
    checks++;
    if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: q=%0d r=%0d dz=%b busy=%b, want 28 4 0 0",
               quotient, remainder, div_by_zero, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] va [4] = '{8'd255, 8'd5, 8'd0, 8'd255};
    logic [7:0] vb [4] = '{8'd1,   8'd9, 8'd3, 8'd255};
    logic [7:0] vq [4] = '{8'd255, 8'd0, 8'd0, 8'd1};
    logic [7:0] vr [4] = '{8'd0,   8'd5, 8'd0, 8'd0};
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i]);
      checks++;
      if (done_at !== 10 || quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL boundary_%0d (%0d/%0d): done_at=%0d q=%0d r=%0d dz=%b, want 10 %0d %0d 0",
                 i, va[i], vb[i], done_at, quotient, remainder, div_by_zero, vq[i], vr[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL boundary_pulse_%0d: done=%b, want 0", i, done);
      end
    end
  endtask

  task automatic test_div_zero();
    run_op(8'd100, 8'd0);
    checks++;
    if (done_at !== 1 || busy_cycles !== 0) begin
      failures++;
      $display("FAIL dz_timing: done_at=%0d busy_cycles=%0d, want 1 0", done_at, busy_cycles);
    end
    checks++;
    if (quotient !== 8'hFF || remainder !== 8'd100 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dz_result: q=%0h r=%0d dz=%b, want ff 100 1", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    run_op(8'd9, 8'd3);
    checks++;
    if (done_at !== 10 || quotient !== 8'd3 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL dz_clear: done_at=%0d q=%0d r=%0d dz=%b, want 10 3 0 0",
               done_at, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_hold_start();
    start = 1'b1;
    data1 = 8'd200;
    data2 = 8'd7;
    @(posedge clk);
    @(negedge clk);
    data1 = 8'd50;
    data2 = 8'd5;
    wait_done();
    checks++;
    if (done_at !== 10 || quotient !== 8'd28 || remainder !== 8'd4) begin
      failures++;
      $display("FAIL hold_first: done_at=%0d q=%0d r=%0d, want 10 28 4", done_at, quotient, remainder);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL hold_idle_gap: busy=%b done=%b, want 0 0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_reaccept: busy=%b, want 1", busy);
    end
    wait_done();
    checks++;
    if (done_at !== 10 || quotient !== 8'd10 || remainder !== 8'd0) begin
      failures++;
      $display("FAIL hold_second: done_at=%0d q=%0d r=%0d, want 10 10 0", done_at, quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen_done;
    start = 1'b1;
    data1 = 8'd200;
    data2 = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      failures++;
      $display("FAIL midreset_outputs: q=%0d r=%0d busy=%b done=%b dz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++;
      $display("FAIL midreset_no_done: %0d cycles with busy/done after abort, want 0", seen_done);
    end
    run_op(8'd81, 8'd9);
    checks++;
    if (done_at !== 10 || quotient !== 8'd9 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL midreset_recover: done_at=%0d q=%0d r=%0d dz=%b, want 10 9 0 0",
               done_at, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_hold_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
